// File: rtl/adc_align_pkg.sv
// Shared lane-state type and default training constants for the ADC lane aligner.
package adc_align_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StSlip,
        StWait,
        StLocked,
        StFail
    } lane_state_t;

    localparam logic [7:0]  DEF_TRAIN_PATTERN = 8'hF0;
    localparam int unsigned DEF_SETTLE_CYCLES = 4;
    localparam int unsigned DEF_MATCH_COUNT   = 16;

endpackage

// File: rtl/adc_lane_align_ch.sv
// One lane of the aligner: compares the lane word to the training pattern and
// walks the deserializer with bitslip pulses until it locks or runs out of positions.
module adc_lane_align_ch
    import adc_align_pkg::*;
#(
    parameter int unsigned            DESER_WIDTH   = 8,
    parameter logic [DESER_WIDTH-1:0] TRAIN_PATTERN = DESER_WIDTH'(DEF_TRAIN_PATTERN),
    parameter int unsigned            SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned            MATCH_COUNT   = DEF_MATCH_COUNT
) (
    input  logic                   divclk,
    input  logic                   rst,
    input  logic                   train_start,
    input  logic [DESER_WIDTH-1:0] lane_data,
    output logic                   bitslip,
    output logic                   lane_locked,
    output logic                   lane_fail,
    output logic                   lane_busy
);

    localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
    localparam int unsigned SW = $clog2(DESER_WIDTH);
    localparam int unsigned WW = $clog2(SETTLE_CYCLES + 1);

    lane_state_t   state_q, state_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d;
    logic [SW-1:0] slip_cnt_q, slip_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge divclk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            match_cnt_q <= '0;
            slip_cnt_q  <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        // A restart overrides any decision the lane would take this cycle.
        if (train_start) begin
            state_d     = StCheck;
            match_cnt_d = '0;
            slip_cnt_d  = '0;
            wait_cnt_d  = '0;
        end else begin
            case (state_q)
                StCheck: begin
                    if (lane_data == TRAIN_PATTERN) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_q == MW'(MATCH_COUNT - 1)) state_d = StLocked;
                    end else if (slip_cnt_q == SW'(DESER_WIDTH - 1)) begin
                        state_d = StFail;
                    end else begin
                        state_d     = StSlip;
                        match_cnt_d = '0;
                        slip_cnt_d  = slip_cnt_q + 1'b1;
                    end
                end
                StSlip: begin
                    state_d    = StWait;
                    wait_cnt_d = '0;
                end
                StWait: begin
                    // Data is ignored here while the deserializer settles on its new phase.
                    if (wait_cnt_q == WW'(SETTLE_CYCLES - 1)) state_d = StCheck;
                    else wait_cnt_d = wait_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bitslip     = (state_q == StSlip);
    assign lane_locked = (state_q == StLocked);
    assign lane_fail   = (state_q == StFail);
    assign lane_busy   = (state_q == StCheck) || (state_q == StSlip) || (state_q == StWait);

endmodule

// File: rtl/adc_lane_align.sv
// Multi-lane ADC word aligner: per-lane training FSMs plus registered data path
// and registered aggregate status.
module adc_lane_align
    import adc_align_pkg::*;
#(
    parameter int unsigned            NUM_LANES     = 8,
    parameter int unsigned            DESER_WIDTH   = 8,
    parameter logic [DESER_WIDTH-1:0] TRAIN_PATTERN = DESER_WIDTH'(DEF_TRAIN_PATTERN),
    parameter int unsigned            SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned            MATCH_COUNT   = DEF_MATCH_COUNT
) (
    input  logic                             divclk,
    input  logic                             rst,
    input  logic [NUM_LANES*DESER_WIDTH-1:0] data_in,
    input  logic                             train_start,
    output logic [NUM_LANES-1:0]             bitslip,
    output logic [NUM_LANES*DESER_WIDTH-1:0] data_out,
    output logic                             data_valid,
    output logic [NUM_LANES-1:0]             lane_locked,
    output logic [NUM_LANES-1:0]             lane_fail,
    output logic                             locked,
    output logic                             fail,
    output logic                             busy
);

    logic [NUM_LANES-1:0] lane_busy;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        adc_lane_align_ch #(
            .DESER_WIDTH   (DESER_WIDTH),
            .TRAIN_PATTERN (TRAIN_PATTERN),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .MATCH_COUNT   (MATCH_COUNT)
        ) u_ch (
            .divclk      (divclk),
            .rst         (rst),
            .train_start (train_start),
            .lane_data   (data_in[k*DESER_WIDTH +: DESER_WIDTH]),
            .bitslip     (bitslip[k]),
            .lane_locked (lane_locked[k]),
            .lane_fail   (lane_fail[k]),
            .lane_busy   (lane_busy[k])
        );
    end

    always_ff @(posedge divclk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            locked   <= 1'b0;
            fail     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            data_out <= data_in;
            locked   <= &lane_locked;
            fail     <= |lane_fail;
            busy     <= |lane_busy;
        end
    end

    assign data_valid = locked;

endmodule

// File: tb/tb_adc_lane_align.sv
// Bench for adc_lane_align: rotating-pattern lane models driven by bitslip, checked
// against expected slip counts and lock/fail timing computed from the training rules.
module tb_adc_lane_align;

    localparam int NL = 8;
    localparam int DW = 8;

    logic              divclk = 1'b0;
    logic              rst = 1'b0;
    logic              train_start = 1'b0;
    logic [NL*DW-1:0]  data_in = '0;
    logic [NL-1:0]     bitslip;
    logic [NL*DW-1:0]  data_out;
    logic              data_valid;
    logic [NL-1:0]     lane_locked;
    logic [NL-1:0]     lane_fail;
    logic              locked;
    logic              fail;
    logic              busy;

    int total = 0;
    int bad = 0;

    // Lane model state: pattern offset, two-cycle bitslip delay line, pulse counts.
    int offset[NL];
    bit p0[NL];
    bit p1[NL];
    int slips[NL];
    bit stuck[NL];
    bit corrupt0 = 1'b0;
    bit rand_mode = 1'b0;
    int cyc = 0;
    int q0[$];

    adc_lane_align u_dut (
        .divclk      (divclk),
        .rst         (rst),
        .data_in     (data_in),
        .train_start (train_start),
        .bitslip     (bitslip),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .lane_locked (lane_locked),
        .lane_fail   (lane_fail),
        .locked      (locked),
        .fail        (fail),
        .busy        (busy)
    );

    always #5 divclk = ~divclk;

    function automatic logic [7:0] word_at(int off);
        logic [15:0] t;
        t = {8'hF0, 8'hF0};
        t = t << off;
        return t[15:8];
    endfunction

    task automatic compute_data();
        logic [7:0] w;
        if (rand_mode) begin
            data_in = {$urandom(), $urandom()};
        end else begin
            for (int k = 0; k < NL; k++) begin
                w = stuck[k] ? 8'h00 : word_at(offset[k]);
                if (k == 0 && corrupt0) w = ~w;
                data_in[k*DW +: DW] = w;
            end
        end
    endtask

    task automatic step();
        @(negedge divclk);
        #1;
        cyc++;
        for (int k = 0; k < NL; k++) begin
            if (p1[k]) offset[k] = (offset[k] + 7) % 8;
            p1[k] = p0[k];
            p0[k] = bitslip[k];
            if (bitslip[k]) begin
                slips[k]++;
                if (k == 0) q0.push_back(cyc);
            end
        end
        compute_data();
    endtask

    task automatic config_lanes(input bit ramp);
        for (int k = 0; k < NL; k++) begin
            offset[k] = ramp ? k : 0;
            p0[k] = 1'b0;
            p1[k] = 1'b0;
            slips[k] = 0;
            stuck[k] = 1'b0;
        end
        q0.delete();
        corrupt0 = 1'b0;
        rand_mode = 1'b0;
        compute_data();
    endtask

    task automatic do_reset();
        train_start = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic pulse_train();
        train_start = 1'b1;
        step();
        train_start = 1'b0;
    endtask

    task automatic test_reset();
        config_lanes(1'b1);
        rst = 1'b1;
        step();
        step();
        total++;
        if ({bitslip, lane_locked, lane_fail, data_valid, locked, fail, busy} !== '0) begin
            bad++;
            $display("FAIL reset_status got %b want 0",
                     {bitslip, lane_locked, lane_fail, data_valid, locked, fail, busy});
        end
        total++;
        if (data_out !== '0) begin
            bad++;
            $display("FAIL reset_data_out got %h want 0", data_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        total++;
        if (busy !== 1'b0 || lane_locked !== '0 || lane_fail !== '0) begin
            bad++;
            $display("FAIL idle_after_reset busy=%b locked=%b fail=%b want all 0",
                     busy, lane_locked, lane_fail);
        end
        for (int k = 0; k < NL; k++) begin
            total++;
            if (slips[k] != 0) begin
                bad++;
                $display("FAIL idle_no_slip lane %0d got %0d want 0", k, slips[k]);
            end
        end
    endtask

    task automatic test_align();
        int n;
        config_lanes(1'b1);
        do_reset();
        pulse_train();
        n = 0;
        while (!locked && n < 300) begin
            step();
            n++;
        end
        // Slowest lane needs 7 slip rounds of 6 cycles, 16 matches, plus the status register.
        total++;
        if (n != 6 * 7 + 16 + 1) begin
            bad++;
            $display("FAIL lock_latency got %0d want %0d", n, 6 * 7 + 16 + 1);
        end
        for (int k = 0; k < NL; k++) begin
            total++;
            if (slips[k] != k) begin
                bad++;
                $display("FAIL align_slips lane %0d got %0d want %0d", k, slips[k], k);
            end
        end
        total++;
        if (lane_locked !== 8'hFF || data_valid !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL align_status lane_locked=%h valid=%b fail=%b busy=%b want ff 1 0 0",
                     lane_locked, data_valid, fail, busy);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (data_valid !== locked || bitslip !== '0) begin
                bad++;
                $display("FAIL hold_locked valid=%b locked=%b bitslip=%h want valid=locked, 0",
                         data_valid, locked, bitslip);
            end
        end
    endtask

    task automatic test_stuck_lane();
        int n;
        config_lanes(1'b1);
        stuck[3] = 1'b1;
        compute_data();
        do_reset();
        pulse_train();
        n = 0;
        while (!(lane_fail[3] && lane_locked == 8'hF7) && n < 300) begin
            step();
            n++;
        end
        step();
        total++;
        if (slips[3] != 7) begin
            bad++;
            $display("FAIL stuck_slips got %0d want 7", slips[3]);
        end
        total++;
        if (lane_fail !== 8'h08 || fail !== 1'b1 || locked !== 1'b0 || data_valid !== 1'b0) begin
            bad++;
            $display("FAIL stuck_status lane_fail=%h fail=%b locked=%b valid=%b want 08 1 0 0",
                     lane_fail, fail, locked, data_valid);
        end
        for (int i = 0; i < 10; i++) step();
        total++;
        if (slips[3] != 7 || locked !== 1'b0 || lane_locked !== 8'hF7) begin
            bad++;
            $display("FAIL stuck_hold slips=%0d locked=%b lane_locked=%h want 7 0 f7",
                     slips[3], locked, lane_locked);
        end
    endtask

    task automatic test_corrupt_word();
        int base;
        int n;
        config_lanes(1'b0);
        do_reset();
        pulse_train();
        base = cyc;
        for (int i = 0; i < 9; i++) step();
        corrupt0 = 1'b1;
        step();
        corrupt0 = 1'b0;
        n = 0;
        while (!lane_fail[0] && n < 300) begin
            step();
            n++;
        end
        step();
        total++;
        if (q0.size() != 7) begin
            bad++;
            $display("FAIL corrupt_slips got %0d want 7", q0.size());
        end
        total++;
        if (q0.size() == 0 || q0[0] - base != 11) begin
            bad++;
            $display("FAIL corrupt_first_slip got %0d want 11", q0.size() ? q0[0] - base : -1);
        end
        for (int i = 1; i < q0.size(); i++) begin
            total++;
            if (q0[i] - q0[i-1] != 6) begin
                bad++;
                $display("FAIL corrupt_slip_gap %0d got %0d want 6", i, q0[i] - q0[i-1]);
            end
        end
        // Starting from offset 0, seven slips leave the lane one position short of aligned.
        total++;
        if (data_out[7:0] !== word_at(1)) begin
            bad++;
            $display("FAIL corrupt_final_word got %h want %h", data_out[7:0], word_at(1));
        end
        total++;
        if (lane_fail !== 8'h01 || lane_locked !== 8'hFE || fail !== 1'b1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL corrupt_status lane_fail=%h lane_locked=%h fail=%b locked=%b",
                     lane_fail, lane_locked, fail, locked);
        end
    endtask

    task automatic test_restart_mid_wait();
        int n;
        config_lanes(1'b1);
        do_reset();
        pulse_train();
        step();
        step();
        step();
        train_start = 1'b1;
        step();
        train_start = 1'b0;
        total++;
        if (bitslip !== '0 || busy !== 1'b1 || lane_locked !== '0) begin
            bad++;
            $display("FAIL restart_cycle bitslip=%h busy=%b lane_locked=%h want 0 1 0",
                     bitslip, busy, lane_locked);
        end
        n = 0;
        while (!locked && n < 300) begin
            step();
            n++;
        end
        total++;
        if (n != 6 * 6 + 16 + 1) begin
            bad++;
            $display("FAIL restart_lock_latency got %0d want %0d", n, 6 * 6 + 16 + 1);
        end
        for (int k = 0; k < NL; k++) begin
            total++;
            if (slips[k] != k) begin
                bad++;
                $display("FAIL restart_slips lane %0d got %0d want %0d", k, slips[k], k);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        config_lanes(1'b0);
        do_reset();
        pulse_train();
        for (int i = 0; i < 15; i++) step();
        // Restart lands on the edge where every lane would have locked.
        train_start = 1'b1;
        step();
        train_start = 1'b0;
        total++;
        if (lane_locked !== '0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL b2b_priority lane_locked=%h locked=%b want 0 0", lane_locked, locked);
        end
        n = 0;
        while (!locked && n < 300) begin
            step();
            n++;
        end
        total++;
        if (n != 17) begin
            bad++;
            $display("FAIL b2b_lock_latency got %0d want 17", n);
        end
        pulse_train();
        total++;
        if (lane_locked !== '0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL relock_lag lane_locked=%h locked=%b want 0 1", lane_locked, locked);
        end
        step();
        total++;
        if (locked !== 1'b0 || data_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL relock_drop locked=%b valid=%b busy=%b want 0 0 1",
                     locked, data_valid, busy);
        end
    endtask

    task automatic test_reset_mid_slip();
        config_lanes(1'b1);
        do_reset();
        pulse_train();
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        #1;
        total++;
        if ({bitslip, lane_locked, lane_fail, data_valid, locked, fail, busy} !== '0 ||
            data_out !== '0) begin
            bad++;
            $display("FAIL async_reset status=%b data_out=%h want 0",
                     {bitslip, lane_locked, lane_fail, data_valid, locked, fail, busy}, data_out);
        end
        step();
        total++;
        if (bitslip !== '0) begin
            bad++;
            $display("FAIL reset_bitslip got %h want 0", bitslip);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) step();
        for (int k = 0; k < NL; k++) begin
            total++;
            if (slips[k] != ((k >= 1) ? 1 : 0)) begin
                bad++;
                $display("FAIL reset_abort_slips lane %0d got %0d want %0d",
                         k, slips[k], (k >= 1) ? 1 : 0);
            end
        end
        total++;
        if (busy !== 1'b0 || lane_locked !== '0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_stays_idle busy=%b lane_locked=%h locked=%b want 0",
                     busy, lane_locked, locked);
        end
    endtask

    task automatic test_random_data();
        logic [NL*DW-1:0] exp;
        config_lanes(1'b0);
        do_reset();
        rand_mode = 1'b1;
        compute_data();
        for (int i = 0; i < 60; i++) begin
            exp = data_in;
            train_start = (i == 10) ? 1'b1 : 1'b0;
            step();
            total++;
            if (data_out !== exp) begin
                bad++;
                $display("FAIL data_delay cycle %0d got %h want %h", i, data_out, exp);
            end
        end
        train_start = 1'b0;
        rand_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_align();
        test_stuck_lane();
        test_corrupt_word();
        test_restart_mid_wait();
        test_back_to_back();
        test_reset_mid_slip();
        test_random_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
